// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-stage state encoding and default widths
package pipe_pkg;
    typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipe_state_t;
    localparam int PIPE_CNT_W_DEFAULT = 16;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter with synchronous reset and increment enable
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int W = PIPE_CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    // count up on inc, sticking at all-ones instead of wrapping
    always_comb begin
        cnt_d = (inc && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
    end
    // counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: ready/valid pipeline stage with 2-entry skid buffer, flush and registered ready.
// Optional stall/bubble performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter bit CLEAR_PAYLOAD = 1'b1
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W         = PIPE_CNT_W_DEFAULT
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
`endif
);
    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             xfer_in, xfer_out;
    // handshakes depend only on registered state, so ready_o has no path from ready_i
    assign ready_o  = (state_q != PS_FULL);
    assign valid_o  = (state_q != PS_EMPTY);
    assign xfer_in  = valid_i && ready_o;
    assign xfer_out = valid_o && ready_i;
    assign data_o   = main_q;
    // next state and payload routing; flush overrides any transfer in this cycle
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = PS_EMPTY;
            main_d  = CLEAR_PAYLOAD ? '0 : main_q;
            skid_d  = CLEAR_PAYLOAD ? '0 : skid_q;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    state_d = xfer_in ? PS_BUSY : PS_EMPTY;
                    main_d  = xfer_in ? data_i : main_q;
                end
                PS_BUSY: begin
                    state_d = xfer_in ? (xfer_out ? PS_BUSY : PS_FULL) : (xfer_out ? PS_EMPTY : PS_BUSY);
                    main_d  = (xfer_in && xfer_out) ? data_i
                            : (!xfer_in && xfer_out && CLEAR_PAYLOAD) ? '0 : main_q;
                    skid_d  = (xfer_in && !xfer_out) ? data_i : skid_q;
                end
                PS_FULL: begin
                    state_d = xfer_out ? PS_BUSY : PS_FULL;
                    main_d  = xfer_out ? skid_q : main_q;
                    skid_d  = (xfer_out && CLEAR_PAYLOAD) ? '0 : skid_q;
                end
                default: begin
                    state_d = PS_EMPTY;
                end
            endcase
        end
    end
    // state and payload registers; reset empties both entries
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PS_EMPTY;
            main_q  <= CLEAR_PAYLOAD ? '0 : main_q;
            skid_q  <= CLEAR_PAYLOAD ? '0 : skid_q;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (valid_o && !ready_i),
        .cnt_o (stall_cnt_o)
    );
    pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!valid_o),
        .cnt_o (bubble_cnt_o)
    );
`endif
endmodule
